instruction_fetch: RTL
======================

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter ADDR_WIDTH, default 16, memory address and program-counter width.
REQ-002 Parameter DATA_WIDTH, default 16, instruction word width.
REQ-003 Parameter RESET_PC, default 0, program-counter value after reset.
REQ-004 Parameter WAIT_LIMIT, default 15, maximum WAIT cycles before timeout, legal range 1..255.
REQ-005 The block SHALL run on one clock; reset is synchronous and active-high.
REQ-006 clock  in  1  rising-edge clock.
REQ-007 reset  in  1  synchronous active-high reset.
REQ-008 run  in  1  level; 1 = fetch continuously, 0 = stop after the current instruction.
REQ-009 jump  in  1  one-cycle pulse; redirect pc to jumpAddr.
REQ-010 jumpAddr  in  ADDR_WIDTH  jump target.
REQ-011 memAddr  out  ADDR_WIDTH  memory read address.
REQ-012 memRead  out  1  memory read request.
REQ-013 memReady  in  1  memory data valid on memData.
REQ-014 memData  in  DATA_WIDTH  memory read data.
REQ-015 dataOut  out  DATA_WIDTH  word for the shared data bus.
REQ-016 dataOE  out  1  bus-drive enable; the external tri-state drives dataOut only while it is 1.
REQ-017 notLoad  out  1  active-low instruction-register load strobe.
REQ-018 pc  out  ADDR_WIDTH  current program counter.
REQ-019 busy  out  1  1 in every state except IDLE.
REQ-020 error  out  1  sticky fetch-timeout flag.

Function
REQ-021 The FSM SHALL use states IDLE, REQ, WAIT, DRIVE, STROBE and HOLD; all outputs SHALL be registered.
REQ-022 IDLE: if run=1 and error=0, go to REQ.
REQ-023 REQ, one cycle: memRead=1, memAddr=pc; go to WAIT.
REQ-024 WAIT: memRead=1; memReady=1 captures memData into an internal word and goes to DRIVE.
REQ-025 WAIT timeout: memReady low for WAIT_LIMIT consecutive WAIT cycles sets error=1 and goes to IDLE; pc is unchanged.
REQ-026 DRIVE, one cycle: dataOE=1, dataOut=word, notLoad=1 (bus setup cycle).
REQ-027 STROBE, one cycle: dataOE=1, notLoad=0; notLoad SHALL be low in no other state.
REQ-028 HOLD, one cycle: dataOE=1, notLoad=1 (hold cycle); pc<=pc+1 modulo 2^ADDR_WIDTH, so 0xFFFF wraps to 0x0000.
REQ-029 After HOLD: run=1 goes to REQ, run=0 goes to IDLE; dataOE=0 in IDLE, REQ and WAIT.
REQ-030 Latency: memReady in WAIT cycle N gives DRIVE N+1, STROBE N+2, HOLD N+3 and REQ N+4, so a back-to-back fetch with zero wait is 5 cycles.
REQ-031 jump in IDLE, REQ or WAIT SHALL set pc<=jumpAddr, abort the fetch (data discarded, no strobe) and go to REQ if run=1, else IDLE.
REQ-032 jump in DRIVE or STROBE SHALL be latched; at HOLD, pc<=jumpAddr replaces the increment.
REQ-033 jump in HOLD SHALL set pc<=jumpAddr instead of pc+1.
REQ-034 run falling mid-fetch SHALL NOT abort; the current instruction completes through HOLD.
REQ-035 error SHALL clear only on reset; while error=1 the FSM stays in IDLE.

Reset
REQ-036 On reset the block SHALL go to IDLE with pc=RESET_PC, memAddr=RESET_PC, memRead=0, dataOut=0, dataOE=0, notLoad=1, busy=0, error=0, the latched jump cleared and the timeout counter cleared.
REQ-037 Reset in any state, including STROBE, SHALL take effect at the next edge and SHALL deassert dataOE and notLoad in the same cycle.

Structure
REQ-038 State encodings and default width constants SHALL live in a shared header, fetch_defs, reused by the instruction register test bench.
REQ-039 The WAIT counter SHALL be one sub-module, fetch_wait_timer, with inputs clear and enable and output expired.

Verification
REQ-040 reset, run=1, memReady in first WAIT cycle, memData=16'hF0F0 at pc 0 -> dataOut=F0F0, dataOE high 3 cycles, notLoad low exactly 1 cycle, pc=1 after HOLD.
REQ-041 pc=16'hFFFF, fetch 16'h1234 -> 1234 strobed, pc wraps to 16'h0000.
REQ-042 WAIT_LIMIT=15, memReady held 0 -> error=1 after 15 WAIT cycles, IDLE, no notLoad pulse, pc unchanged; start later ignored until reset.
REQ-043 jump with jumpAddr=16'h0040 during WAIT -> no strobe, next memAddr=0x0040; jump during STROBE -> instruction still loaded, pc=0x0040 after HOLD.
REQ-044 run dropped during DRIVE -> STROBE and HOLD complete, then IDLE with busy=0; reset asserted in STROBE -> notLoad=1, dataOE=0, pc=RESET_PC next cycle.

Source files
------------

// File: rtl/fetch_defs.sv
// rtl/fetch_defs.sv - shared state encodings and width defaults for the fetch unit
package fetch_defs;

    localparam int DEF_ADDR_WIDTH = 16;
    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_WAIT_LIMIT = 15;
    localparam int TIMER_WIDTH    = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_REQ    = 3'd1,
        ST_WAIT   = 3'd2,
        ST_DRIVE  = 3'd3,
        ST_STROBE = 3'd4,
        ST_HOLD   = 3'd5
    } fetch_state_t;

    // The shared data bus is owned by the fetch unit for the whole
    // setup / strobe / hold window.
    function automatic logic drives_bus(input fetch_state_t s);
        return (s == ST_DRIVE) || (s == ST_STROBE) || (s == ST_HOLD);
    endfunction

    // A memory request is outstanding from REQ until data or timeout.
    function automatic logic reads_mem(input fetch_state_t s);
        return (s == ST_REQ) || (s == ST_WAIT);
    endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// rtl/instruction_fetch_if.sv - instruction memory read port
interface instruction_fetch_if #(
    parameter int ADDR_WIDTH = fetch_defs::DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = fetch_defs::DEF_DATA_WIDTH
) ();

    logic [ADDR_WIDTH-1:0] memAddr;
    logic                  memRead;
    logic                  memReady;
    logic [DATA_WIDTH-1:0] memData;

    modport master (
        output memAddr,
        output memRead,
        input  memReady,
        input  memData
    );

    modport slave (
        input  memAddr,
        input  memRead,
        output memReady,
        output memData
    );

endinterface

// File: rtl/fetch_wait_timer.sv
// rtl/fetch_wait_timer.sv - counts consecutive memory wait cycles
module fetch_wait_timer
    import fetch_defs::*;
#(
    parameter int WAIT_LIMIT = DEF_WAIT_LIMIT
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [TIMER_WIDTH-1:0] LAST_COUNT = TIMER_WIDTH'(WAIT_LIMIT - 1);

    logic [TIMER_WIDTH-1:0] count;

    // Count enabled cycles; clear whenever the fetch leaves WAIT.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    // Fires during the WAIT_LIMIT-th consecutive enabled cycle so the FSM
    // can leave WAIT on that same edge.
    assign expired = enable && (count == LAST_COUNT);

endmodule

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - instruction fetch sequencer with IR load strobe
module instruction_fetch
    import fetch_defs::*;
#(
    parameter int                    ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int                    DATA_WIDTH = DEF_DATA_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter int                    WAIT_LIMIT = DEF_WAIT_LIMIT
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  run,
    input  logic                  jump,
    input  logic [ADDR_WIDTH-1:0] jumpAddr,
    instruction_fetch_if.master   mem,
    output logic [DATA_WIDTH-1:0] dataOut,
    output logic                  dataOE,
    output logic                  notLoad,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic                  busy,
    output logic                  error
);

    fetch_state_t          state;
    fetch_state_t          state_nxt;
    logic [ADDR_WIDTH-1:0] pc_nxt;
    logic                  jump_pend;
    logic                  jump_pend_nxt;
    logic [ADDR_WIDTH-1:0] jump_addr_q;
    logic [ADDR_WIDTH-1:0] jump_addr_nxt;
    logic                  error_nxt;
    logic                  capture;
    logic                  resume;
    logic                  timer_clear;
    logic                  timer_enable;
    logic                  wait_expired;

    assign resume       = run && !error;
    assign timer_clear  = (state != ST_WAIT);
    assign timer_enable = (state == ST_WAIT) && !mem.memReady;

    fetch_wait_timer #(
        .WAIT_LIMIT (WAIT_LIMIT)
    ) u_wait_timer (
        .clock   (clock),
        .reset   (reset),
        .clear   (timer_clear),
        .enable  (timer_enable),
        .expired (wait_expired)
    );

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, pc update, jump latching and timeout decision.
    always_comb begin
        state_nxt     = state;
        pc_nxt        = pc;
        jump_pend_nxt = jump_pend;
        jump_addr_nxt = jump_addr_q;
        error_nxt     = error;
        capture       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (jump) begin
                    pc_nxt = jumpAddr;
                end
                if (resume) begin
                    state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                if (jump) begin
                    pc_nxt    = jumpAddr;
                    state_nxt = resume ? ST_REQ : ST_IDLE;
                end else begin
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // A redirect abandons the outstanding read; any data is dropped.
                if (jump) begin
                    pc_nxt    = jumpAddr;
                    state_nxt = resume ? ST_REQ : ST_IDLE;
                end else if (mem.memReady) begin
                    capture   = 1'b1;
                    state_nxt = ST_DRIVE;
                end else if (wait_expired) begin
                    error_nxt = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            ST_DRIVE, ST_STROBE: begin
                // The instruction is already on the bus; defer the redirect
                // until HOLD so the load completes.
                if (jump) begin
                    jump_pend_nxt = 1'b1;
                    jump_addr_nxt = jumpAddr;
                end
                state_nxt = (state == ST_DRIVE) ? ST_STROBE : ST_HOLD;
            end
            ST_HOLD: begin
                if (jump) begin
                    pc_nxt = jumpAddr;
                end else if (jump_pend) begin
                    pc_nxt = jump_addr_q;
                end else begin
                    pc_nxt = pc + 1'b1;
                end
                jump_pend_nxt = 1'b0;
                state_nxt     = resume ? ST_REQ : ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Registered outputs, all derived from the state being entered so they
    // are valid for the whole cycle spent in that state.
    always_ff @(posedge clock) begin
        if (reset) begin
            pc          <= RESET_PC;
            mem.memAddr <= RESET_PC;
            mem.memRead <= 1'b0;
            dataOut     <= '0;
            dataOE      <= 1'b0;
            notLoad     <= 1'b1;
            busy        <= 1'b0;
            error       <= 1'b0;
            jump_pend   <= 1'b0;
            jump_addr_q <= '0;
        end else begin
            pc          <= pc_nxt;
            mem.memRead <= reads_mem(state_nxt);
            dataOE      <= drives_bus(state_nxt);
            notLoad     <= (state_nxt != ST_STROBE);
            busy        <= (state_nxt != ST_IDLE);
            error       <= error_nxt;
            jump_pend   <= jump_pend_nxt;
            jump_addr_q <= jump_addr_nxt;
            if (state_nxt == ST_REQ) begin
                mem.memAddr <= pc_nxt;
            end
            if (capture) begin
                dataOut <= mem.memData;
            end
        end
    end

endmodule
